// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO read/write controllers.
package fifo_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int unsigned s = 1; s < 32; s = s << 1)
            b = b ^ (b >> s);
        return b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit after 'last', wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        int unsigned j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            j = (32'(last) + i) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Async FIFO write-side controller: round-robin burst arbiter, write pointer
// (binary and Gray) and registered full flag in the wclk domain.
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter  int ASIZE = 4,
    parameter  int DSIZE = 8,
    parameter  int NREQ  = 4,
    parameter  int BURST = 4,
    localparam int GW    = idx_width(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic [ASIZE:0]        wq2_rptr,
    output logic [ASIZE:0]        wptr,
    output logic [ASIZE-1:0]      waddr,
    output logic [DSIZE-1:0]      wdata,
    output logic                  wen,
    output logic                  wfull,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
);

    localparam int CW = idx_width(BURST);

    state_t          state, state_n;
    logic [GW-1:0]   owner, owner_n;
    logic [GW-1:0]   last, last_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [ASIZE:0]  wbin, wbinnext, wgraynext;
    logic            full_next;
    logic            found;
    logic [GW-1:0]   pick;
    logic            own_valid;

    rr_pick #(.N(NREQ), .W(GW)) u_pick (
        .req   (req_valid),
        .last  (last),
        .found (found),
        .idx   (pick)
    );

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        last_n    = last;
        cnt_n     = cnt;
        wen       = 1'b0;
        req_ready = '0;
        own_valid = req_valid[owner];
        wdata     = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            if (owner == GW'(i))
                wdata = req_data[i*DSIZE +: DSIZE];

        unique case (state)
            IDLE: begin
                if (found && !wfull) begin
                    owner_n = pick;
                    last_n  = pick;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (own_valid && !wfull) begin
                    wen              = 1'b1;
                    req_ready[owner] = 1'b1;
                    if (cnt == CW'(BURST - 1)) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else if (!own_valid) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Full when the next Gray write pointer laps the synchronized read pointer.
    assign wbinnext  = wbin + {{ASIZE{1'b0}}, wen};
    assign wgraynext = (ASIZE+1)'(bin2gray(32'(wbinnext)));
    assign full_next = (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state <= IDLE;
            owner <= '0;
            last  <= GW'(NREQ - 1);
            cnt   <= '0;
            wbin  <= '0;
            wptr  <= '0;
            wfull <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            cnt   <= cnt_n;
            wbin  <= wbinnext;
            wptr  <= wgraynext;
            wfull <= full_next;
        end
    end

    assign waddr    = wbin[ASIZE-1:0];
    assign grant_id = owner;
    assign busy     = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: cycle tables, hand sequences and a write scoreboard.
module tb_fifo_wr_arb;

    localparam int ASIZE = 4;
    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [ASIZE:0]        wq2_rptr = '0;
    logic [ASIZE:0]        wptr;
    logic [ASIZE-1:0]      waddr;
    logic [DSIZE-1:0]      wdata;
    logic                  wen, wfull, busy;
    logic [1:0]            grant_id;

    always #5 wclk = ~wclk;

    fifo_wr_arb #(.ASIZE(ASIZE), .DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wq2_rptr  (wq2_rptr),
        .wptr      (wptr),
        .waddr     (waddr),
        .wdata     (wdata),
        .wen       (wen),
        .wfull     (wfull),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    typedef struct {
        logic [ASIZE-1:0] addr;
        int               req;
        logic [DSIZE-1:0] data;
    } wr_t;

    typedef struct {
        logic [3:0] v;
        logic       wen;
        logic [3:0] rdy;
        logic       busy;
        logic [1:0] gid;
        logic [4:0] wptr;
    } row_t;

    wr_t  sb[$];
    row_t tbl[7];
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] acc_cnt [NREQ] = '{default: 4'd0};
    int   exp_word [NREQ] = '{default: 0};

    // Each requester presents {id, sequence number}; the number advances on acceptance.
    always_comb
        for (int i = 0; i < NREQ; i++)
            req_data[i*DSIZE +: DSIZE] = {4'(i), acc_cnt[i]};

    always @(posedge wclk)
        if (!wrst)
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i])
                    acc_cnt[i] <= acc_cnt[i] + 4'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int r, input int addr);
        wr_t e;
        e.addr = ASIZE'(addr);
        e.req  = r;
        e.data = {4'(r), 4'(exp_word[r])};
        exp_word[r]++;
        sb.push_back(e);
    endtask

    task automatic tk();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic e_wen, input logic e_busy, input logic [1:0] e_gid);
        chk({tag, "_wen"}, 32'(wen), 32'(e_wen));
        chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
        if (e_busy)
            chk({tag, "_gid"}, 32'(grant_id), 32'(e_gid));
    endtask

    task automatic do_reset(input logic [3:0] v);
        tk();
        wrst      = 1'b1;
        req_valid = v;
        wq2_rptr  = '0;
        repeat (3) begin
            @(negedge wclk);
            chk("rst_wen", 32'(wen), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_wptr", 32'(wptr), 32'd0);
            chk("rst_wfull", 32'(wfull), 32'd0);
        end
        tk();
        wrst = 1'b0;
    endtask

    // Every write strobe must match the next queued expectation.
    always @(negedge wclk) begin
        if (!wrst && wen) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", waddr, wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("sb_addr", 32'(waddr), 32'(e.addr));
                chk("sb_data", 32'(wdata), 32'(e.data));
                chk("sb_ready", 32'(req_ready), 32'(4'b0001 << e.req));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_full;

        tbl[0] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 5'b00000};
        tbl[1] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 5'b00000};
        tbl[2] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 5'b00001};
        tbl[3] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 5'b00011};
        tbl[4] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 5'b00010};
        tbl[5] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2'd2, 5'b00110};
        tbl[6] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 5'b00110};

        // All requesters valid: four full bursts in order 0..3 fill the FIFO.
        do_reset(4'b1111);
        for (int r = 0; r < NREQ; r++)
            for (int k = 0; k < BURST; k++)
                push_exp(r, r*BURST + k);
        @(negedge wclk);
        chk_state("all_bubble", 1'b0, 1'b0, 2'd0);
        tk();
        @(negedge wclk);
        chk_state("all_first", 1'b1, 1'b1, 2'd0);
        got_full = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (wfull) begin
                got_full = 1'b1;
                break;
            end
            tk();
            @(negedge wclk);
        end
        chk("full_reached", 32'(got_full), 32'd1);
        chk("full_wptr", 32'(wptr), 32'b11000);
        chk("full_drained", 32'(sb.size()), 32'd0);
        repeat (3) begin
            tk();
            @(negedge wclk);
            chk_state("full_hold", 1'b0, 1'b0, 2'd0);
            chk("full_hold_flag", 32'(wfull), 32'd1);
        end

        // Read side frees one slot: exactly one write at address 0, then full again.
        tk();
        wq2_rptr = 5'b00001;
        @(negedge wclk);
        chk("rel_still_full", 32'(wfull), 32'd1);
        push_exp(0, 0);
        tk();
        @(negedge wclk);
        chk("rel_wfull", 32'(wfull), 32'd0);
        tk();
        @(negedge wclk);
        chk_state("rel_write", 1'b1, 1'b1, 2'd0);
        tk();
        @(negedge wclk);
        chk("rel_refull", 32'(wfull), 32'd1);
        chk_state("rel_stall", 1'b0, 1'b1, 2'd0);
        tk();
        @(negedge wclk);
        chk_state("rel_stall2", 1'b0, 1'b1, 2'd0);

        // Single requester 2: table of per-cycle outputs.
        do_reset(4'b0100);
        for (int a = 0; a < 5; a++)
            push_exp(2, a);
        for (int r = 0; r < 7; r++) begin
            req_valid = tbl[r].v;
            @(negedge wclk);
            chk($sformatf("tbl%0d_wen", r), 32'(wen), 32'(tbl[r].wen));
            chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
            if (tbl[r].busy)
                chk($sformatf("tbl%0d_gid", r), 32'(grant_id), 32'(tbl[r].gid));
            chk($sformatf("tbl%0d_wptr", r), 32'(wptr), 32'(tbl[r].wptr));
            tk();
        end
        req_valid = '0;

        // Early yield by requester 1 after two words; requester 2 then gets a full burst.
        do_reset(4'b0110);
        push_exp(1, 0);
        push_exp(1, 1);
        for (int a = 2; a < 6; a++)
            push_exp(2, a);
        @(negedge wclk);
        chk_state("ey_bubble", 1'b0, 1'b0, 2'd0);
        tk();
        @(negedge wclk);
        chk_state("ey_w0", 1'b1, 1'b1, 2'd1);
        tk();
        @(negedge wclk);
        chk_state("ey_w1", 1'b1, 1'b1, 2'd1);
        tk();
        req_valid = 4'b0100;
        @(negedge wclk);
        chk_state("ey_yield", 1'b0, 1'b1, 2'd1);
        tk();
        @(negedge wclk);
        chk_state("ey_idle", 1'b0, 1'b0, 2'd0);
        for (int k = 0; k < BURST; k++) begin
            tk();
            @(negedge wclk);
            chk_state($sformatf("ey_r2_w%0d", k), 1'b1, 1'b1, 2'd2);
        end
        tk();
        req_valid = '0;
        @(negedge wclk);
        chk_state("ey_end", 1'b0, 1'b0, 2'd0);
        chk("ey_waddr", 32'(waddr), 32'd6);

        // Asynchronous reset in the middle of a burst.
        do_reset(4'b1111);
        push_exp(0, 0);
        push_exp(0, 1);
        @(negedge wclk);
        tk();
        @(negedge wclk);
        chk_state("mb_w0", 1'b1, 1'b1, 2'd0);
        tk();
        @(negedge wclk);
        chk_state("mb_w1", 1'b1, 1'b1, 2'd0);
        tk();
        wrst = 1'b1;
        #1;
        chk("mb_rst_wen", 32'(wen), 32'd0);
        chk("mb_rst_busy", 32'(busy), 32'd0);
        chk("mb_rst_ready", 32'(req_ready), 32'd0);
        chk("mb_rst_wptr", 32'(wptr), 32'd0);
        chk("mb_rst_waddr", 32'(waddr), 32'd0);
        chk("mb_rst_wfull", 32'(wfull), 32'd0);
        @(negedge wclk);
        tk();
        wrst = 1'b0;
        push_exp(0, 0);
        @(negedge wclk);
        chk_state("mb_bubble", 1'b0, 1'b0, 2'd0);
        tk();
        @(negedge wclk);
        chk_state("mb_regrant", 1'b1, 1'b1, 2'd0);
        tk();
        req_valid = '0;
        @(negedge wclk);
        chk_state("mb_drop", 1'b0, 1'b1, 2'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
